// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO of {instr, pc} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] winstr,
  input  logic [XLEN-1:0] wpc,
  output logic [XLEN-1:0] rinstr,
  output logic [XLEN-1:0] rpc,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    do_pop  = pop & ~empty;
    // A push into a full buffer is legal when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    rinstr  = mem_q[rd_ptr_q].instr;
    rpc     = mem_q[rd_ptr_q].pc;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(reset || flush)) mem_q[wr_ptr_q] <= '{instr: winstr, pc: wpc};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential reads, buffers responses, handles redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReqF,
  output logic [31:0] PCF,
  input  logic [31:0] ImemRdF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q;
  logic            inflight_q, inflight_d;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic [XLEN-1:0] head_instr, head_pc;
  logic [OccW-1:0] occ;
  logic            valid, deq, issue, push, pop;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (PCSrcE),
    .winstr(ImemRdF),
    .wpc   (inflight_pc_q),
    .rinstr(head_instr),
    .rpc   (head_pc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    valid = ~fifo_empty & ~reset;
    deq   = valid & ~StallD;
    // Slots already committed (buffered + inflight) minus the one leaving this cycle.
    occ   = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, deq};
    issue = ~reset & ~PCSrcE & (occ < DepthOcc);
    // Redirect squashes the response arriving this cycle and overrides dequeue.
    pop   = deq & ~PCSrcE;
    push  = inflight_q & ~PCSrcE & ~reset & (~fifo_full | pop);

    inflight_d = issue;
    pc_d       = pc_q;
    if (PCSrcE)     pc_d = align_pc(PCTargetE);
    else if (issue) pc_d = pc_q + 32'd4;

    ImemReqF = issue;
    PCF      = pc_q;
    ValidD   = valid;
    InstrD   = valid ? head_instr : NOP_INSTR;
    PCD      = valid ? head_pc : '0;
    PCPlus4D = PCD + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scenario tasks plus an in-order PC scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ImemReqF;
  logic [31:0] PCF;
  logic [31:0] ImemRdF;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        StallD = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD, PCD, PCPlus4D;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  fetch_unit #(
    .RESET_PC(RstPc),
    .DEPTH   (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ImemReqF (ImemReqF),
    .PCF      (PCF),
    .ImemRdF  (ImemRdF),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .StallD   (StallD),
    .ValidD   (ValidD),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory: data valid the cycle after the request.
  always @(posedge clk) ImemRdF <= ImemReqF ? mem_word(PCF) : 32'hDEAD_BEEF;

  task automatic load_path(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Scoreboard: every instruction accepted by decode must be the next one on the path.
  always @(negedge clk) begin
    if (!reset && !PCSrcE && ValidD && !StallD) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow: got PCD=%h, required no instruction", PCD);
      end else begin
        sb_exp = exp_q.pop_front();
        if (PCD !== sb_exp || InstrD !== mem_word(sb_exp) || PCPlus4D !== sb_exp + 32'd4)
          $display("FAIL sb_order: got PCD=%h InstrD=%h PCPlus4D=%h, required %h %h %h",
                   PCD, InstrD, PCPlus4D, sb_exp, mem_word(sb_exp), sb_exp + 32'd4);
        else passes++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ImemReqF !== 1'b0) $display("FAIL reset_req: got %b, required 0", ImemReqF); else passes++;
    checks++; if (ValidD !== 1'b0) $display("FAIL reset_valid: got %b, required 0", ValidD); else passes++;
    checks++; if (InstrD !== NOP_INSTR) $display("FAIL reset_instr: got %h, required %h", InstrD, NOP_INSTR); else passes++;
    checks++; if (PCD !== 32'h0) $display("FAIL reset_pcd: got %h, required 0", PCD); else passes++;
    checks++; if (PCPlus4D !== 32'h4) $display("FAIL reset_pc4: got %h, required 4", PCPlus4D); else passes++;
    checks++; if (PCF !== RstPc) $display("FAIL reset_pcf: got %h, required %h", PCF, RstPc); else passes++;
  endtask

  task automatic test_stream();
    load_path(RstPc);
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (ImemReqF !== 1'b1) $display("FAIL stream_req c%0d: got %b, required 1", c, ImemReqF); else passes++;
      checks++; if (PCF !== RstPc + 32'(4 * c)) $display("FAIL stream_pcf c%0d: got %h, required %h", c, PCF, RstPc + 32'(4 * c)); else passes++;
      checks++; if (ValidD !== (c >= 2)) $display("FAIL stream_valid c%0d: got %b, required %b", c, ValidD, (c >= 2)); else passes++;
      if (c >= 2) begin
        checks++; if (PCPlus4D !== RstPc + 32'(4 * (c - 1))) $display("FAIL stream_pc4 c%0d: got %h, required %h", c, PCPlus4D, RstPc + 32'(4 * (c - 1))); else passes++;
      end
    end
  endtask

  task automatic test_stall();
    @(posedge clk); #1 StallD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ImemReqF !== 1'b0) $display("FAIL stall_req k%0d: got %b, required 0", k, ImemReqF); else passes++;
      checks++; if (ValidD !== 1'b1 || PCD !== exp_q[0] || InstrD !== mem_word(exp_q[0]))
        $display("FAIL stall_hold k%0d: got valid=%b PCD=%h InstrD=%h, required 1 %h %h", k, ValidD, PCD, InstrD, exp_q[0], mem_word(exp_q[0]));
      else passes++;
    end
    @(posedge clk); #1 StallD = 1'b0;
    @(negedge clk);
    checks++; if (ImemReqF !== 1'b1) $display("FAIL stall_release_req: got %b, required 1", ImemReqF); else passes++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect_inflight();
    @(posedge clk); #1 PCSrcE = 1'b1; PCTargetE = 32'h0000_0100; load_path(32'h0000_0100);
    @(negedge clk);
    checks++; if (ImemReqF !== 1'b0) $display("FAIL redir_suppress: got %b, required 0", ImemReqF); else passes++;
    @(posedge clk); #1 PCSrcE = 1'b0; PCTargetE = 32'hDEAD_BEE0;
    @(negedge clk);
    checks++; if (PCF !== 32'h100 || ImemReqF !== 1'b1) $display("FAIL redir_pcf: got %h req=%b, required 00000100 1", PCF, ImemReqF); else passes++;
    checks++; if (ValidD !== 1'b0) $display("FAIL redir_squash1: got %b, required 0", ValidD); else passes++;
    @(negedge clk);
    checks++; if (ValidD !== 1'b0) $display("FAIL redir_squash2: got %b, required 0", ValidD); else passes++;
    @(negedge clk);
    checks++; if (ValidD !== 1'b1 || PCD !== 32'h100) $display("FAIL redir_first: got valid=%b PCD=%h, required 1 00000100", ValidD, PCD); else passes++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect_stall_full();
    @(posedge clk); #1 StallD = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; load_path(32'h0000_0200);
    @(negedge clk);
    checks++; if (ImemReqF !== 1'b0) $display("FAIL rsf_suppress: got %b, required 0", ImemReqF); else passes++;
    @(posedge clk); #1 PCSrcE = 1'b0;
    @(negedge clk);
    checks++; if (ValidD !== 1'b0 || InstrD !== NOP_INSTR) $display("FAIL rsf_flush: got valid=%b InstrD=%h, required 0 %h", ValidD, InstrD, NOP_INSTR); else passes++;
    checks++; if (PCF !== 32'h200 || ImemReqF !== 1'b1) $display("FAIL rsf_pcf: got %h req=%b, required 00000200 1", PCF, ImemReqF); else passes++;
    @(posedge clk); #1 StallD = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_wrap();
    @(posedge clk); #1 PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; load_path(32'hFFFF_FFFC);
    @(posedge clk); #1 PCSrcE = 1'b0;
    @(negedge clk);
    checks++; if (PCF !== 32'hFFFF_FFFC) $display("FAIL wrap_pcf0: got %h, required fffffffc", PCF); else passes++;
    @(negedge clk);
    checks++; if (PCF !== 32'h0) $display("FAIL wrap_pcf1: got %h, required 0", PCF); else passes++;
    @(negedge clk);
    checks++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) $display("FAIL wrap_pcd0: got %h/%h, required fffffffc/0", PCD, PCPlus4D); else passes++;
    @(negedge clk);
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h4) $display("FAIL wrap_pcd1: got %h/%h, required 0/4", PCD, PCPlus4D); else passes++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (ImemReqF !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP_INSTR)
      $display("FAIL rmid_during: got req=%b valid=%b InstrD=%h, required 0 0 %h", ImemReqF, ValidD, InstrD, NOP_INSTR);
    else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ValidD !== 1'b0 || PCF !== RstPc) $display("FAIL rmid_state: got valid=%b PCF=%h, required 0 %h", ValidD, PCF, RstPc); else passes++;
    load_path(RstPc);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ImemReqF !== 1'b1 || PCF !== RstPc) $display("FAIL rmid_first_req: got req=%b PCF=%h, required 1 %h", ImemReqF, PCF, RstPc); else passes++;
    @(negedge clk);
    checks++; if (ValidD !== 1'b0) $display("FAIL rmid_stale: got valid=%b PCD=%h, required 0", ValidD, PCD); else passes++;
    @(negedge clk);
    checks++; if (ValidD !== 1'b1 || PCD !== RstPc) $display("FAIL rmid_first: got valid=%b PCD=%h, required 1 %h", ValidD, PCD, RstPc); else passes++;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_stall_full();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
